window3x3_gen: RTL and testbench
================================

# window3x3_gen

- Streaming 3x3 window generator. Feeds the nine-operand kernel adder that sits downstream of it.
- Accepts one N-bit pixel per cycle in raster order for a WIDTH x HEIGHT frame. Buffers the two previous lines.
- Each time a pixel completes a fully interior 3x3 neighbourhood, it presents all nine window pixels in parallel on op1..op9 with a valid strobe.
- Sits between the pixel source and the kernel adder; no backpressure (the adder accepts every cycle).

## Interface

Parameters:
- N, default 8: pixel width in bits.
- WIDTH, default 16: pixels per line, legal range 3 or more.
- HEIGHT, default 16: lines per frame, legal range 3 or more.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_data is a pixel this cycle.
- in_sof, input, 1: qualified by in_valid; marks pixel (row 0, col 0) of a new frame.
- in_data, input, N: pixel value.
- op1..op9, output, N each: window pixels, registered.
- out_valid, output, 1: op1..op9 hold a new window this cycle.
- out_last, output, 1: qualified by out_valid; last window of the frame.

## Operation

- Position counters:
  - col counts 0..WIDTH-1; row counts 0..HEIGHT-1.
  - Both advance only on in_valid. col wraps to 0 and increments row; row wraps to 0 after (HEIGHT-1, WIDTH-1).
  - Counter widths are $clog2 of the respective parameter.
- in_sof:
  - A pixel with in_valid & in_sof is taken as position (0,0) regardless of the counters. The counters resume from (0,1).
  - Partial-frame contents need no clearing; the row/col gating below masks them.
  - in_sof without in_valid is ignored.
- Line buffers:
  - Two memories of WIDTH x N. LB1 holds line r-1, LB2 holds line r-2, indexed by col.
  - On each accepted pixel at col c: read LB1[c] and LB2[c], then write LB2[c] <= LB1[c] and LB1[c] <= in_data.
  - Line buffer contents are not reset.
- Window registers: a 3x3 shift array.
  - Each accepted pixel shifts every row left by one column.
  - The new right-hand column is loaded: top = LB2[c], middle = LB1[c], bottom = in_data.
- Window mapping for accepted pixel (r,c):
  - op1,op2,op3 = line r-2, cols c-2, c-1, c.
  - op4,op5,op6 = line r-1, cols c-2, c-1, c.
  - op7,op8,op9 = line r, cols c-2, c-1, c (op9 is the accepted pixel).
- Window emission:
  - A window is emitted only when the accepted pixel has r >= 2 and c >= 2.
  - Windows never straddle a line wrap.
  - Exactly (WIDTH-2)*(HEIGHT-2) windows are emitted per complete frame.
- out_last is asserted with the window whose op9 is pixel (HEIGHT-1, WIDTH-1).
- When no window is emitted: out_valid = 0 and op1..op9 hold their last values.
- No arithmetic is performed; the data path is pure storage and moves.

## Timing

- Reset values:
  - out_valid = 0, out_last = 0, op1..op9 = 0.
  - Counters = 0; window array = 0.
  - Reset takes effect immediately, asynchronously, including mid-frame. The first pixel after reset is treated as (0,0) even without in_sof.
- Latency:
  - A pixel accepted at rising edge t produces its window on outputs after edge t.
  - out_valid is high for exactly the cycle between edges t and t+1.
- Throughput: one window per cycle when in_valid is held high through interior pixels.
- Gaps: idle cycles (in_valid = 0) freeze counters, line buffers and the window array. Output windows are identical to the gap-free case; only their timing shifts.
- Back-to-back frames:
  - (HEIGHT-1, WIDTH-1) followed immediately by (0,0) of the next frame needs no bubble.
  - No window of the new frame is emitted before its pixel (2,2), so there is no stale-line mixing.
- in_sof on (0,0) when the counters are already at (0,0) is a no-op.

## Test plan

- WIDTH=4, HEIGHT=4, one frame, pixel value 4*r+c, in_valid held high:
  - out_valid appears after the pixel-10, 11, 14 and 15 edges only.
  - First window is op1..op9 = 0,1,2,4,5,6,8,9,10.
  - Last window is 5,6,7,9,10,11,13,14,15 with out_last = 1.
- Same frame with a 2-cycle in_valid gap after every pixel: same four windows and values. Each out_valid is one cycle wide; outputs hold between windows.
- Two consecutive WIDTH=4, HEIGHT=4 frames, second frame pixel = 100+4*r+c:
  - Exactly eight windows total.
  - Fifth window is 100,101,102,104,105,106,108,109,110.
- in_sof asserted at pixel 6 of frame 1, then a full 16-pixel frame: only the four windows of the new frame are emitted, values relative to the new (0,0).
- Assert rst mid-frame after pixel 9:
  - Outputs drop to 0 immediately.
  - A following full frame yields the four correct windows, the first being 0,1,2,4,5,6,8,9,10.
- Default WIDTH=16, HEIGHT=16, random pixels: 196 windows per frame. Each window matches a software 3x3 crop, and out_last is on the 196th.

Source files
------------

// File: rtl/window3x3_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | window3x3_gen_if : pixel-in / window-out bundle for window3x3_gen|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface window3x3_gen_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_sof;
  logic [N-1:0] in_data;
  logic [N-1:0] op1, op2, op3, op4, op5, op6, op7, op8, op9;
  logic         out_valid;
  logic         out_last;

  modport master (
    output in_valid, in_sof, in_data,
    input  op1, op2, op3, op4, op5, op6, op7, op8, op9, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output op1, op2, op3, op4, op5, op6, op7, op8, op9, out_valid, out_last
  );
endinterface
`default_nettype wire

// File: rtl/window3x3_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | window3x3_gen : streaming 3x3 window generator, two line buffers |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module window3x3_gen #(
  parameter int N      = 8,
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  window3x3_gen_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] C_COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] C_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] C_ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d, pos_c;
  logic [RW-1:0] row_q, row_d, pos_r;
  logic          emit, emit_last;
  logic [N-1:0]  lb1_rd, lb2_rd;

  logic [N-1:0]  lb1_q [WIDTH];
  logic [N-1:0]  lb2_q [WIDTH];
  logic [N-1:0]  win_q [3][3];
  logic [N-1:0]  op_q  [9];
  logic          out_valid_q, out_last_q;

  // A start-of-frame pixel is (0,0) no matter where the counters are.
  always_comb begin
    pos_c     = (bus.in_valid && bus.in_sof) ? '0 : col_q;
    pos_r     = (bus.in_valid && bus.in_sof) ? '0 : row_q;
    col_d     = col_q;
    row_d     = row_q;
    if (bus.in_valid) begin
      if (pos_c == C_COL_LAST) begin
        col_d = '0;
        row_d = (pos_r == C_ROW_LAST) ? '0 : pos_r + RW'(1);
      end else begin
        col_d = pos_c + CW'(1);
        row_d = pos_r;
      end
    end
    emit      = bus.in_valid && (pos_r >= C_ROW_TWO) && (pos_c >= C_COL_TWO);
    emit_last = emit && (pos_r == C_ROW_LAST) && (pos_c == C_COL_LAST);
    lb1_rd    = lb1_q[pos_c];
    lb2_rd    = lb2_q[pos_c];
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb2_q[pos_c] <= lb1_rd;
      lb1_q[pos_c] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      for (int k = 0; k < 9; k++)
        op_q[k] <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= emit;
      out_last_q  <= emit_last;
      if (bus.in_valid) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_rd;
        win_q[1][2] <= lb1_rd;
        win_q[2][2] <= bus.in_data;
      end
      // Outputs take the post-shift window, so build it from pre-shift state.
      if (emit) begin
        op_q[0] <= win_q[0][1];
        op_q[1] <= win_q[0][2];
        op_q[2] <= lb2_rd;
        op_q[3] <= win_q[1][1];
        op_q[4] <= win_q[1][2];
        op_q[5] <= lb1_rd;
        op_q[6] <= win_q[2][1];
        op_q[7] <= win_q[2][2];
        op_q[8] <= bus.in_data;
      end
    end
  end

  assign bus.op1       = op_q[0];
  assign bus.op2       = op_q[1];
  assign bus.op3       = op_q[2];
  assign bus.op4       = op_q[3];
  assign bus.op5       = op_q[4];
  assign bus.op6       = op_q[5];
  assign bus.op7       = op_q[6];
  assign bus.op8       = op_q[7];
  assign bus.op9       = op_q[8];
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
endmodule
`default_nettype wire

// File: tb/tb_window3x3_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_window3x3_gen : random/directed frames vs. 3x3 crop model      |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_window3x3_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, rst_l;
  logic       d_valid, d_sof;
  logic [7:0] d_data;
  int         sel;
  int         cur_w, cur_h;

  window3x3_gen_if #(.N(8)) s_if ();
  window3x3_gen_if #(.N(8)) l_if ();

  assign s_if.in_valid = d_valid && (sel == 0);
  assign s_if.in_sof   = d_sof;
  assign s_if.in_data  = d_data;
  assign l_if.in_valid = d_valid && (sel == 1);
  assign l_if.in_sof   = d_sof;
  assign l_if.in_data  = d_data;

  window3x3_gen #(.N(8), .WIDTH(4),  .HEIGHT(4))  u_small (.clk(clk), .rst(rst_s), .bus(s_if.slave));
  window3x3_gen #(.N(8), .WIDTH(16), .HEIGHT(16)) u_large (.clk(clk), .rst(rst_l), .bus(l_if.slave));

  logic [7:0] s_ops [9];
  logic [7:0] l_ops [9];
  always_comb begin
    s_ops[0] = s_if.op1; s_ops[1] = s_if.op2; s_ops[2] = s_if.op3;
    s_ops[3] = s_if.op4; s_ops[4] = s_if.op5; s_ops[5] = s_if.op6;
    s_ops[6] = s_if.op7; s_ops[7] = s_if.op8; s_ops[8] = s_if.op9;
    l_ops[0] = l_if.op1; l_ops[1] = l_if.op2; l_ops[2] = l_if.op3;
    l_ops[3] = l_if.op4; l_ops[4] = l_if.op5; l_ops[5] = l_if.op6;
    l_ops[6] = l_if.op7; l_ops[7] = l_if.op8; l_ops[8] = l_if.op9;
  end

  int n_vec = 0;
  int n_bad = 0;
  int nwin;
  int img [16][16];
  int lexp [2][9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_op(input int k);
    return (sel == 1) ? l_ops[k] : s_ops[k];
  endfunction

  function automatic logic get_valid();
    return (sel == 1) ? l_if.out_valid : s_if.out_valid;
  endfunction

  function automatic logic get_last();
    return (sel == 1) ? l_if.out_last : s_if.out_last;
  endfunction

  task automatic check_outputs(input bit emit, input bit last);
    chk("out_valid", {31'b0, get_valid()}, {31'b0, emit});
    chk("out_last", {31'b0, get_last()}, {31'b0, last});
    for (int k = 0; k < 9; k++)
      chk($sformatf("op%0d", k + 1), {24'b0, get_op(k)}, lexp[sel][k] & 32'hff);
    if (get_valid()) nwin++;
  endtask

  // One pixel at position (r,c) of the current frame, then `gap` idle cycles.
  task automatic send(input int r, input int c, input int v, input bit sof, input int gap);
    bit emit;
    img[r][c] = v;
    d_valid = 1'b1;
    d_sof   = sof;
    d_data  = v[7:0];
    @(posedge clk); #1;
    d_valid = 1'b0;
    d_sof   = 1'b0;
    emit = (r >= 2) && (c >= 2);
    if (emit)
      for (int k = 0; k < 9; k++)
        lexp[sel][k] = img[r - 2 + k / 3][c - 2 + k % 3];
    check_outputs(emit, emit && (r == cur_h - 1) && (c == cur_w - 1));
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check_outputs(1'b0, 1'b0);
    end
  endtask

  task automatic small_frame(input int base, input int gap, input bit sof);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send(r, c, base + 4 * r + c, sof && r == 0 && c == 0, gap);
  endtask

  initial begin
    d_valid = 1'b0; d_sof = 1'b0; d_data = '0; sel = 0;
    cur_w = 4; cur_h = 4;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 9; k++) lexp[s][k] = 0;
    rst_s = 1'b1; rst_l = 1'b1;
    #12;
    sel = 0; check_outputs(1'b0, 1'b0);
    sel = 1; check_outputs(1'b0, 1'b0);
    sel = 0;
    @(negedge clk); rst_s = 1'b0; rst_l = 1'b0;
    @(posedge clk); #1;

    nwin = 0; small_frame(0, 0, 1'b0);
    chk("win_count_plain", nwin, 4);

    nwin = 0; small_frame(0, 2, 1'b0);
    chk("win_count_gap", nwin, 4);

    nwin = 0; small_frame(0, 0, 1'b1); small_frame(100, 0, 1'b0);
    chk("win_count_b2b", nwin, 8);

    nwin = 0;
    for (int p = 0; p < 6; p++) send(p / 4, p % 4, 50 + p, 1'b0, 0);
    small_frame(200, 0, 1'b1);
    chk("win_count_sof", nwin, 4);

    for (int p = 0; p < 10; p++) send(p / 4, p % 4, 30 + p, 1'b0, 0);
    #2 rst_s = 1'b1;
    #1;
    for (int k = 0; k < 9; k++) lexp[0][k] = 0;
    check_outputs(1'b0, 1'b0);
    @(negedge clk); rst_s = 1'b0;
    @(posedge clk); #1;
    nwin = 0; small_frame(0, 0, 1'b0);
    chk("win_count_rst", nwin, 4);

    sel = 1; cur_w = 16; cur_h = 16;
    for (int f = 0; f < 2; f++) begin
      nwin = 0;
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          send(r, c, int'($urandom_range(0, 255)), f == 1 && r == 0 && c == 0,
               (f == 1) ? int'($urandom_range(0, 1)) : 0);
      chk("win_count_large", nwin, 196);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
